// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared types and sizes for the truth-table sweeper
// Exports: state_t (IDLE, SETTLE, FINISH), NUM_VEC (vectors per sweep), IDX_W (vector index width)
package truth_table_sweeper_pkg;
    localparam int NUM_VEC = 8;
    localparam int IDX_W = 3;
    typedef enum logic [1:0] {IDLE, SETTLE, FINISH} state_t;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: control/result bundle between a sweep requester and the sweeper
// master: drives start, expected; receives busy, done, pass, truth_table, mismatch
// slave:  the sweeper side of the same signals
interface truth_table_sweeper_if;
    import truth_table_sweeper_pkg::*;
    logic               start;
    logic [NUM_VEC-1:0] expected;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_VEC-1:0] truth_table;
    logic [NUM_VEC-1:0] mismatch;
    modport master (output start, expected, input busy, done, pass, truth_table, mismatch);
    modport slave  (input start, expected, output busy, done, pass, truth_table, mismatch);
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// truth_table_sweeper_settle_timer: loadable down-counter timing how long each vector is held
// Ports: clk, reset_n (async active-low), load (reload to SETTLE_CYCLES-1),
//        en (count down while nonzero), zero (counter has reached 0)
module truth_table_sweeper_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= CNT_W'(SETTLE_CYCLES - 1);
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all {g,v,y} vectors to a 3-in/1-out block and checks its truth table
// Ports: clk, reset_n (async active-low), bus (slave: start/expected in; busy/done/pass/
//        truth_table/mismatch out), g_out/v_out/y_out (vector index bits 2/1/0), j_in (block output)
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    truth_table_sweeper_if.slave bus,
    output logic                 g_out,
    output logic                 v_out,
    output logic                 y_out,
    input  logic                 j_in
);
    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [NUM_VEC-1:0] tt, tt_nxt, exp_q, mm;
    logic               pass_q, zero, accept, sample, last, load;

    truth_table_sweeper_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .en     (state == SETTLE),
        .zero   (zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    // tt_nxt folds in the bit sampled this edge so the final compare sees the complete table
    always_comb begin
        accept = bus.start && state != SETTLE;
        sample = state == SETTLE && zero;
        last = sample && idx == IDX_W'(NUM_VEC - 1);
        load = accept || (sample && !last);
        tt_nxt = tt;
        tt_nxt[idx] = j_in;
        state_nxt = accept ? SETTLE : last ? FINISH : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
            tt <= '0;
            exp_q <= '0;
            mm <= '0;
            pass_q <= 1'b0;
        end else if (accept) begin
            idx <= '0;
            tt <= '0;
            exp_q <= bus.expected;
            mm <= '0;
            pass_q <= 1'b0;
        end else if (sample) begin
            tt <= tt_nxt;
            if (last) begin
                pass_q <= (tt_nxt == exp_q);
                mm <= tt_nxt ^ exp_q;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign {g_out, v_out, y_out} = idx;
    assign bus.busy = (state == SETTLE);
    assign bus.done = (state == FINISH);
    assign bus.pass = pass_q;
    assign bus.truth_table = tt;
    assign bus.mismatch = mm;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for truth_table_sweeper at SETTLE_CYCLES of 2 and 1
module tb_truth_table_sweeper;
    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [7:0] mm;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic g0, v0, y0, g1, v1, y1, j0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];

    truth_table_sweeper_if if0 ();
    truth_table_sweeper_if if1 ();

    assign j0 = (g0 & v0) | y0;

    truth_table_sweeper dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0),
        .g_out(g0), .v_out(v0), .y_out(y0), .j_in(j0)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1),
        .g_out(g1), .v_out(v1), .y_out(y1), .j_in(1'b1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_tt();
        logic [7:0] t;
        for (int k = 0; k < 8; k++) t[k] = (k[2] & k[1]) | k[0];
        return t;
    endfunction

    function automatic logic [31:0] outs0();
        return {if0.busy, if0.done, if0.pass, if0.truth_table, if0.mismatch, g0, v0, y0};
    endfunction

    function automatic logic [31:0] outs1();
        return {if1.busy, if1.done, if1.pass, if1.truth_table, if1.mismatch, g1, v1, y1};
    endfunction

    // Runs one sweep on the selected DUT and compares the result against the scoreboard entry
    task automatic sweep(input bit sel, input logic [7:0] exp_val, input bit disturb);
        exp_t e;
        int   s, lat, bad_n;
        bit   seen;
        logic [2:0] vec, bad_vec;
        logic b, d, p;
        logic [7:0] t, m;
        s = sel ? 1 : 2;
        e.tt = sel ? 8'hFF : model_tt();
        e.pass = (e.tt == exp_val);
        e.mm = e.tt ^ exp_val;
        sb.push_back(e);
        @(negedge clk);
        if (sel) begin if1.start = 1'b1; if1.expected = exp_val; end
        else begin if0.start = 1'b1; if0.expected = exp_val; end
        @(posedge clk); #1;
        if0.start = 1'b0; if1.start = 1'b0;
        b = sel ? if1.busy : if0.busy;
        d = sel ? if1.done : if0.done;
        vec = sel ? {g1, v1, y1} : {g0, v0, y0};
        checks++;
        if ({b, d, vec} !== 5'b10000) begin
            fails++;
            $display("FAIL sweep_start busy/done/vec got %b%b/%0d, want 10/0", b, d, vec);
        end
        seen = 0; lat = 0; bad_n = -1; bad_vec = '0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (disturb && n == 5) if0.start = 1'b1;
            if (disturb && n == 6) begin if0.start = 1'b0; if0.expected = ~exp_val; end
            d = sel ? if1.done : if0.done;
            vec = sel ? {g1, v1, y1} : {g0, v0, y0};
            if (d) begin seen = 1; lat = n; end
            else if (bad_n < 0 && vec !== 3'(n / s)) begin bad_n = n; bad_vec = vec; end
        end
        checks++;
        if (bad_n >= 0) begin
            fails++;
            $display("FAIL vector_hold at cycle %0d got %0d, want %0d", bad_n, bad_vec, bad_n / s);
        end
        checks++;
        if (!seen || lat != 8 * s) begin
            fails++;
            $display("FAIL done_latency got %0d (seen=%0d), want %0d", lat, seen, 8 * s);
        end
        e = sb.pop_front();
        b = sel ? if1.busy : if0.busy;
        p = sel ? if1.pass : if0.pass;
        t = sel ? if1.truth_table : if0.truth_table;
        m = sel ? if1.mismatch : if0.mismatch;
        vec = sel ? {g1, v1, y1} : {g0, v0, y0};
        checks++;
        if (t !== e.tt) begin fails++; $display("FAIL truth_table got %h, want %h", t, e.tt); end
        checks++;
        if (p !== e.pass) begin fails++; $display("FAIL pass got %b, want %b", p, e.pass); end
        checks++;
        if (m !== e.mm) begin fails++; $display("FAIL mismatch got %h, want %h", m, e.mm); end
        checks++;
        if ({b, vec} !== 4'b0111) begin
            fails++;
            $display("FAIL finish_outputs busy/vec got %b/%0d, want 0/7", b, vec);
        end
        repeat (3) @(posedge clk);
        #1;
        d = sel ? if1.done : if0.done;
        t = sel ? if1.truth_table : if0.truth_table;
        checks++;
        if ({d, t} !== {1'b1, e.tt}) begin
            fails++;
            $display("FAIL finish_hold done/tt got %b/%h, want 1/%h", d, t, e.tt);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset_n = 1'b0;
        if0.start = 1'b1; if0.expected = 8'hFF;
        if1.start = 1'b1; if1.expected = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs0() !== '0 || outs1() !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %h/%h, want 0/0", outs0(), outs1());
        end
        @(negedge clk);
        if0.start = 1'b0; if1.start = 1'b0;
        reset_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (if0.busy || if0.done || if1.busy || if1.done) bad++;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL idle_no_start busy/done asserted in %0d cycles, want 0", bad); end
    endtask

    task automatic test_pass_sweep();
        sweep(0, 8'hEA, 0);
    endtask

    task automatic test_fail_sweep();
        sweep(0, 8'hE8, 0);
    endtask

    task automatic test_ignored_start();
        sweep(0, 8'hEA, 1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        if0.start = 1'b1; if0.expected = 8'hEA;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (outs0() !== '0 || outs1() !== '0) begin
            fails++;
            $display("FAIL async_reset_mid got %h/%h, want 0/0", outs0(), outs1());
        end
        @(negedge clk);
        reset_n = 1'b1;
        sweep(0, 8'hEA, 0);
    endtask

    task automatic test_settle1_restart();
        sweep(1, 8'hFF, 0);
        checks++;
        if (if1.done !== 1'b1) begin fails++; $display("FAIL restart_precondition done got %b, want 1", if1.done); end
        sweep(1, 8'hFF, 0);
    endtask

    initial begin
        test_reset();
        test_pass_sweep();
        test_fail_sweep();
        test_ignored_start();
        test_reset_mid();
        test_settle1_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Hardware counterpart to a stimulus-only bench for a 3-input/1-output combinational block. On a start request it drives every input combination {g,v,y} in order from 000 to 111. After each vector it waits a programmable settle time, samples the block's output j, and assembles an 8-bit truth table. It compares that table against an expected table latched at start and reports pass/fail with a per-entry mismatch mask. It sits beside the device under test in lab characterization designs, replacing manual $monitor inspection.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before j_in is sampled; legal range is 1 or greater.
CNT_W, $clog2(SETTLE_CYCLES+1), settle counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; ignored while busy=1
expected  input  8  expected truth table; bit k = expected j for vector index k
g_out  output  1  drives g of the DUT; index bit 2
v_out  output  1  drives v of the DUT; index bit 1
y_out  output  1  drives y of the DUT; index bit 0
j_in  input  1  DUT output being characterized
busy  output  1  sweep in progress
done  output  1  sweep complete; held until the next accepted start or reset
pass  output  1  valid when done=1; 1 when truth_table equals the latched expected value
truth_table  output  8  captured j values; bit k = j for index k
mismatch  output  8  truth_table XOR latched expected; valid when done=1

Behaviour:
- Reset is asynchronous and active-low, one clock. While reset_n=0:
  - state=IDLE, index=0, settle counter=0.
  - g_out/v_out/y_out=0, busy=0, done=0, pass=0, truth_table=0, mismatch=0, latched expected=0.
- States:
  - IDLE: wait for start.
  - SETTLE: hold vector {g,v,y}=index while the counter runs.
  - FINISH: done asserted, outputs stable.
- Start acceptance:
  - In IDLE or FINISH, start=1 at edge E0 is accepted.
  - From E0: state=SETTLE, index=0, counter=SETTLE_CYCLES-1, busy=1, done=0, pass=0, truth_table=0, mismatch=0, expected latched.
- SETTLE, each edge:
  - If counter != 0, decrement it.
  - If counter == 0, write j_in into truth_table[index].
  - Then, if index==7: go to FINISH, busy=0, done=1, pass=(final table == latched expected), mismatch=final table XOR latched expected. The final table includes the bit being written at this same edge.
  - Otherwise: index+1, counter reloaded to SETTLE_CYCLES-1.
- Vector outputs:
  - {g_out,v_out,y_out}=index, registered; they change only at the edge that advances index.
  - Each vector is held for exactly SETTLE_CYCLES cycles.
- Latency: done rises at edge E0 + 8*SETTLE_CYCLES. With the default setting, done rises 16 cycles after start is sampled.
- start while busy=1 is ignored. The sweep and latched expected are unaffected; a change on the expected input mid-sweep has no effect.
- FINISH holds index=7 (vector 111 stays driven), together with truth_table, pass, mismatch and done, until the next accepted start.
- Reset asserted mid-sweep aborts immediately to reset values; no partial result is retained.
- j_in is sampled only at counter==0 edges; glitches between sample edges are ignored.

Decomposition:
- Shared package: state enum (IDLE, SETTLE, FINISH), NUM_VEC=8, IDX_W=3.
- One natural sub-module, settle_timer: a loadable down-counter with load, en and zero outputs, parameterized by SETTLE_CYCLES. Instantiated once.

Test Plan:
- Reset and idle: hold reset_n=0 with start=1 -> all outputs stay 0; release reset with no start -> busy and done stay 0 indefinitely.
- Pass sweep: DUT model j=(g&v)|y, expected=8'hEA, start pulse -> vectors 000..111 each held 2 cycles, done at start+16, truth_table=8'hEA, pass=1, mismatch=8'h00.
- Fail sweep: same DUT model, expected=8'hE8 -> truth_table=8'hEA, pass=0, mismatch=8'h02.
- Ignored start and mid-sweep expected change: pulse start again at cycle 5 and change expected at cycle 6 -> single sweep completes at start+16 with the original expected value; pass unchanged.
- Reset mid-sweep: drop reset_n at cycle 7 -> all outputs are 0 immediately, asynchronously; after release a new start gives a full correct sweep.
- Timing and restart: SETTLE_CYCLES=1, j_in tied to 1 -> done at start+8, truth_table=8'hFF; start again while in FINISH -> done clears at E0 and the sweep repeats.
